// File: rtl/rf_write_arbiter_if.sv
// Writeback bus between the two requesters (A: ALU, B: load return) and the
// register-file write port, including the hold/freeze control.
interface rf_write_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              hold;
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              rf_rw;
    logic [ADDR_W-1:0] rf_d_addr;
    logic [DATA_W-1:0] rf_data;
    logic              last_grant;

    modport master (
        output hold, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, rf_rw, rf_d_addr, rf_data, last_grant
    );

    modport slave (
        input  hold, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, rf_rw, rf_d_addr, rf_data, last_grant
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// the ALU writeback (A) and the load return path (B); winning write is registered.
module rf_write_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter bit PRIO_A_FIRST = 1'b1,
    parameter bit DROP_R0      = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    rf_write_arbiter_if.slave   bus
);
    logic              grant_a;
    logic              grant_b;
    logic              open_q;
    logic              drop_a;
    logic              drop_b;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              last_grant_q;

    // last_grant_q = 1 means B won last, so A takes the next conflict.
    always_comb begin
        open_q  = !rst && !bus.hold;
        grant_a = open_q && bus.a_valid && (!bus.b_valid || last_grant_q);
        grant_b = open_q && bus.b_valid && (!bus.a_valid || !last_grant_q);
        drop_a  = DROP_R0 && (bus.a_addr == '0);
        drop_b  = DROP_R0 && (bus.b_addr == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rw_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            last_grant_q <= PRIO_A_FIRST;
        end else if (grant_a) begin
            rw_q         <= !drop_a;
            addr_q       <= bus.a_addr;
            data_q       <= bus.a_data;
            last_grant_q <= 1'b0;
        end else if (grant_b) begin
            rw_q         <= !drop_b;
            addr_q       <= bus.b_addr;
            data_q       <= bus.b_data;
            last_grant_q <= 1'b1;
        end else begin
            rw_q         <= 1'b0;
        end
    end

    assign bus.a_ready    = grant_a;
    assign bus.b_ready    = grant_b;
    assign bus.rf_rw      = rw_q;
    assign bus.rf_d_addr  = addr_q;
    assign bus.rf_data    = data_q;
    assign bus.last_grant = last_grant_q;
endmodule
